// File: rtl/ffn_mm_sequencer_pkg.sv
// Shared FFN sequencer definitions: default geometry, address widths and FSM state encoding.
package ffn_mm_sequencer_pkg;

  localparam int FFN_NUM_INPUTS  = 256;
  localparam int FFN_NUM_NEURONS = 10;
  localparam int NUM_MM_BUFFER   = 2;
  localparam int FFN_RD_LAT      = 1;
  localparam int FFN_OUT_WIDTH   = 58;
  localparam int FFN_FM_ADDR_W   = 8;
  localparam int FFN_WT_ADDR_W   = 12;
  localparam int FFN_NEUR_W      = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_DRAIN = 3'd2,
    ST_EMIT  = 3'd3,
    ST_WAIT  = 3'd4
  } mm_state_e;

endpackage

// File: rtl/ffn_mm_sequencer_vld_delay.sv
// Delays the address-valid strobe by the memory read latency so it lines up with data at the MAC.
module ffn_vld_delay #(
  parameter int RD_LAT = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic vld_in,
  output logic vld_out
);

  if (RD_LAT == 0) begin : g_pass
    assign vld_out = vld_in;
  end else begin : g_pipe
    logic [RD_LAT-1:0] sr;

    // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) sr <= '0;
      else        sr <= RD_LAT'({sr, vld_in});
    end

    assign vld_out = sr[RD_LAT-1];
  end

endmodule

// File: rtl/ffn_mm_sequencer.sv
// FFN MAC controller: walks NUM_NEURONS dot products over one frame buffer, captures each sum_b
// into a valid/ready output register, then releases and rotates to the next buffer.
module ffn_mm_sequencer
  import ffn_mm_sequencer_pkg::*;
#(
  parameter int NUM_INPUTS  = FFN_NUM_INPUTS,
  parameter int NUM_NEURONS = FFN_NUM_NEURONS,
  parameter int NUM_BUF     = NUM_MM_BUFFER,
  parameter int RD_LAT      = FFN_RD_LAT,
  parameter int OUT_W       = FFN_OUT_WIDTH,
  parameter int FM_ADDR_W   = FFN_FM_ADDR_W,
  parameter int WT_ADDR_W   = FFN_WT_ADDR_W,
  parameter int NEUR_W      = FFN_NEUR_W
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_BUF-1:0]   frame_rdy,
  output logic [NUM_BUF-1:0]   reading_frame,
  output logic                 frame_done,
  output logic [FM_ADDR_W-1:0] fm_addr,
  output logic [WT_ADDR_W-1:0] wt_addr,
  output logic [NEUR_W-1:0]    bias_addr,
  output logic                 mac_en,
  input  logic [OUT_W-1:0]     mac_sum_b,
  output logic [OUT_W-1:0]     out_data,
  output logic [NEUR_W-1:0]    out_idx,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy
);

  mm_state_e            state, state_nxt;
  logic [FM_ADDR_W-1:0] term;
  logic [WT_ADDR_W-1:0] wt_cnt;
  logic [NEUR_W-1:0]    neuron;
  logic [2:0]           drain_cnt;
  logic                 addr_vld;
  logic                 last_term;
  logic                 last_neuron;
  logic                 last_drain;
  logic                 frame_go;

  assign last_term   = (term == FM_ADDR_W'(NUM_INPUTS - 1));
  assign last_neuron = (neuron == NEUR_W'(NUM_NEURONS - 1));
  assign last_drain  = (drain_cnt == 3'(RD_LAT - 1));
  assign frame_go    = (|(frame_rdy & reading_frame)) && !out_valid;
  assign addr_vld    = (state == ST_RUN);

  assign fm_addr   = term;
  assign wt_addr   = wt_cnt;
  assign bias_addr = neuron;
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: state_nxt gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (frame_go) state_nxt = ST_RUN;
      ST_RUN:   if (last_term) state_nxt = (RD_LAT == 0) ? ST_EMIT : ST_DRAIN;
      ST_DRAIN: if (last_drain) state_nxt = ST_EMIT;
      ST_EMIT:  state_nxt = last_neuron ? ST_IDLE : ST_WAIT;
      ST_WAIT:  if (!out_valid || out_ready) state_nxt = ST_RUN;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Counters saturate at their last value; the weight address is a running count, not neuron*N+term.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      term      <= '0;
      wt_cnt    <= '0;
      neuron    <= '0;
      drain_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          term   <= '0;
          wt_cnt <= '0;
          neuron <= '0;
        end
        ST_RUN: begin
          drain_cnt <= '0;
          if (!last_term) begin
            term   <= term + 1'b1;
            wt_cnt <= wt_cnt + 1'b1;
          end
        end
        ST_DRAIN: drain_cnt <= drain_cnt + 3'd1;
        ST_EMIT: begin
          term <= '0;
          if (last_neuron) begin
            neuron <= '0;
            wt_cnt <= '0;
          end else begin
            neuron <= neuron + 1'b1;
            wt_cnt <= wt_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // EMIT's load wins over a same-cycle accept; WAIT guarantees the register is free before EMIT.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_idx       <= '0;
      frame_done    <= 1'b0;
      reading_frame <= NUM_BUF'(1);
    end else begin
      frame_done <= 1'b0;
      if (state == ST_EMIT) begin
        out_valid <= 1'b1;
        out_data  <= mac_sum_b;
        out_idx   <= neuron;
        if (last_neuron) begin
          frame_done    <= 1'b1;
          reading_frame <= {reading_frame[NUM_BUF-2:0], reading_frame[NUM_BUF-1]};
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  ffn_vld_delay #(.RD_LAT(RD_LAT)) u_vld_delay (
    .clock   (clock),
    .reset   (reset),
    .vld_in  (addr_vld),
    .vld_out (mac_en)
  );

endmodule

// File: tb/tb_ffn_mm_sequencer.sv
// Bench for ffn_mm_sequencer: three builds (RD_LAT 1, 0, 3) each with a MAC and latency-matched
// memory model; expected results come from a plain dot-product reference.
module tb_ffn_mm_sequencer;

  localparam int N    = 4;
  localparam int NN   = 2;
  localparam int NB   = 2;
  localparam int OW   = 58;
  localparam int FW   = 8;
  localparam int WW   = 12;
  localparam int NW   = 4;
  localparam int LAT0 = 1;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic [NB-1:0] frame_rdy [3];
  logic          out_ready [3];

  logic [7:0] feat [NB][N];
  logic [7:0] wt   [NN*N];
  logic [7:0] bias [NN];

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_total = 0;
  int n_pass  = 0;

  for (genvar g = 0; g < 3; g++) begin : g_i
    localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 0 : 3);

    logic [NB-1:0] reading_frame;
    logic          frame_done;
    logic [FW-1:0] fm_addr;
    logic [WW-1:0] wt_addr;
    logic [NW-1:0] bias_addr;
    logic          mac_en;
    logic [OW-1:0] mac_sum_b;
    logic [OW-1:0] out_data;
    logic [NW-1:0] out_idx;
    logic          out_valid;
    logic          busy;

    ffn_mm_sequencer #(
      .NUM_INPUTS(N), .NUM_NEURONS(NN), .NUM_BUF(NB), .RD_LAT(LAT),
      .OUT_W(OW), .FM_ADDR_W(FW), .WT_ADDR_W(WW), .NEUR_W(NW)
    ) dut (
      .clock         (clock),
      .reset         (reset),
      .frame_rdy     (frame_rdy[g]),
      .reading_frame (reading_frame),
      .frame_done    (frame_done),
      .fm_addr       (fm_addr),
      .wt_addr       (wt_addr),
      .bias_addr     (bias_addr),
      .mac_en        (mac_en),
      .mac_sum_b     (mac_sum_b),
      .out_data      (out_data),
      .out_idx       (out_idx),
      .out_valid     (out_valid),
      .out_ready     (out_ready[g]),
      .busy          (busy)
    );

    // Memory read data {feature, weight, bias}, delivered LAT cycles after the address.
    logic [23:0] rd_now;
    logic [23:0] rd_pipe [4];
    logic [23:0] rd_mac;
    always_comb rd_now = {feat[(reading_frame == 2'b10) ? 1 : 0][int'(fm_addr)],
                          wt[int'(wt_addr)], bias[int'(bias_addr)]};
    always @(posedge clock) begin
      rd_pipe[0] <= rd_now;
      for (int i = 1; i < 4; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    if (LAT == 0) begin : g_l0
      assign rd_mac = rd_now;
    end else begin : g_ln
      assign rd_mac = rd_pipe[LAT-1];
    end

    // MAC: en low loads zero next edge; no reset of its own.
    logic [OW-1:0] acc = '0;
    always @(posedge clock) begin
      if (!mac_en) acc <= '0;
      else         acc <= acc + OW'(rd_mac[23:16]) * OW'(rd_mac[15:8]);
    end
    assign mac_sum_b = acc + OW'(rd_mac[7:0]);

    logic [OW-1:0] m_data [16];
    logic [NW-1:0] m_idx  [16];
    int            m_cyc  [16];
    int            m_n  = 0;
    int            fd_n = 0;
    always @(negedge clock) begin
      if (out_valid && out_ready[g] && m_n < 16) begin
        m_data[m_n] <= out_data;
        m_idx[m_n]  <= out_idx;
        m_cyc[m_n]  <= cyc;
        m_n         <= m_n + 1;
      end
      if (frame_done) fd_n <= fd_n + 1;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clock);
    @(negedge clock);
  endtask

  function automatic logic [63:0] ref_out(input int b, input int n);
    longint s = longint'(bias[n]);
    for (int t = 0; t < N; t++) s += longint'(feat[b][t]) * longint'(wt[n*N + t]);
    return 64'(s);
  endfunction

  task automatic load_directed;
    for (int t = 0; t < N; t++) begin
      feat[0][t] = 8'(t + 1);
      feat[1][t] = 8'(t + 1);
      wt[t]      = 8'd1;
      wt[N + t]  = 8'd2;
    end
    bias[0] = 8'd5;
    bias[1] = 8'd0;
  endtask

  task automatic randomize_data;
    for (int b = 0; b < NB; b++)
      for (int t = 0; t < N; t++) feat[b][t] = 8'($urandom);
    for (int i = 0; i < NN*N; i++) wt[i] = 8'($urandom);
    for (int n = 0; n < NN; n++) bias[n] = 8'($urandom);
  endtask

  // Runs one frame on the RD_LAT=1 build, checking every cycle against the timing rules.
  task automatic run_frame(input int b, input int stall, input bit drop);
    int k = 0;
    logic [NB-1:0] rf_exp = NB'(1) << b;
    logic [NB-1:0] rf_rot = {rf_exp[NB-2:0], rf_exp[NB-1]};
    if (stall > 0) out_ready[0] = 1'b0;
    while (!g_i[0].busy && k < 20) begin
      tick;
      k++;
    end
    check("frame_start", 64'(g_i[0].busy), 64'(1));
    if (!g_i[0].busy) return;
    check("reading_frame", 64'(g_i[0].reading_frame), 64'(rf_exp));
    if (drop) frame_rdy[0] = '0;
    for (int n = 0; n < NN; n++) begin
      for (int c = 0; c <= N + LAT0 + 1; c++) begin
        if (c > 0) tick;
        check("mac_en", 64'(g_i[0].mac_en), 64'(c >= LAT0 && c < N + LAT0));
        if (c <= N + LAT0) begin
          check("bias_addr", 64'(g_i[0].bias_addr), 64'(n));
          check("out_valid_low", 64'(g_i[0].out_valid), 64'(0));
          check("fm_addr", 64'(g_i[0].fm_addr), 64'((c < N) ? c : N - 1));
          check("wt_addr", 64'(g_i[0].wt_addr), 64'(n*N + ((c < N) ? c : N - 1)));
        end else begin
          check("out_valid", 64'(g_i[0].out_valid), 64'(1));
          check("out_idx", 64'(g_i[0].out_idx), 64'(n));
          check("out_data", 64'(g_i[0].out_data), ref_out(b, n));
          check("frame_done", 64'(g_i[0].frame_done), 64'(n == NN - 1));
          check("busy_after_emit", 64'(g_i[0].busy), 64'(n != NN - 1));
          if (n == NN - 1) check("rotate", 64'(g_i[0].reading_frame), 64'(rf_rot));
        end
      end
      if (n == 0 && stall > 0) begin
        for (int s = 0; s < stall; s++) begin
          tick;
          check("stall_mac_en", 64'(g_i[0].mac_en), 64'(0));
          check("stall_valid", 64'(g_i[0].out_valid), 64'(1));
          check("stall_data", 64'(g_i[0].out_data), ref_out(b, 0));
          check("stall_fm_addr", 64'(g_i[0].fm_addr), 64'(0));
        end
        out_ready[0] = 1'b1;
      end
      if (n < NN - 1) tick;
    end
    tick;
    check("frame_done_pulse", 64'(g_i[0].frame_done), 64'(0));
  endtask

  initial begin
    int k;
    int fd0;
    for (int g = 0; g < 3; g++) begin
      frame_rdy[g] = '0;
      out_ready[g] = 1'b1;
    end
    randomize_data();
    load_directed();

    // Reset values
    repeat (3) @(negedge clock);
    check("rst_reading_frame", 64'(g_i[0].reading_frame), 64'(1));
    check("rst_frame_done", 64'(g_i[0].frame_done), 64'(0));
    check("rst_fm_addr", 64'(g_i[0].fm_addr), 64'(0));
    check("rst_wt_addr", 64'(g_i[0].wt_addr), 64'(0));
    check("rst_mac_en", 64'(g_i[0].mac_en), 64'(0));
    check("rst_out_valid", 64'(g_i[0].out_valid), 64'(0));
    check("rst_out_data", 64'(g_i[0].out_data), 64'(0));
    check("rst_busy", 64'(g_i[0].busy), 64'(0));
    reset = 1'b1;
    tick;

    // Directed frame on buffer 0, all three builds together
    frame_rdy[0] = 2'b01;
    frame_rdy[1] = 2'b01;
    frame_rdy[2] = 2'b01;
    run_frame(0, 0, 1'b0);
    check("directed_result_1", 64'(g_i[0].out_data), 64'(20));

    // Output stall on buffer 1; frame_rdy dropped mid-frame; other builds lose frame_rdy mid-run
    frame_rdy[1] = '0;
    frame_rdy[2] = '0;
    frame_rdy[0] = 2'b10;
    run_frame(1, 10, 1'b1);

    // Back-to-back random frames: buffer 0, buffer 1, wrap to buffer 0
    randomize_data();
    fd0 = g_i[0].fd_n;
    frame_rdy[0] = 2'b11;
    run_frame(0, 0, 1'b0);
    run_frame(1, 0, 1'b0);
    frame_rdy[0] = 2'b01;
    for (int t = 0; t < N; t++) feat[0][t] = 8'($urandom);
    run_frame(0, 0, 1'b0);
    repeat (4) tick;
    check("idle_after_wrap", 64'(g_i[0].busy), 64'(0));
    check("frame_done_count", 64'(g_i[0].fd_n - fd0), 64'(3));
    check("wrap_reading_frame", 64'(g_i[0].reading_frame), 64'(2'b10));

    // Asynchronous reset in RUN at term 2, then re-run buffer 0
    load_directed();
    frame_rdy[0] = 2'b10;
    k = 0;
    while (!g_i[0].busy && k < 20) begin
      tick;
      k++;
    end
    tick;
    tick;
    check("pre_reset_term", 64'(g_i[0].fm_addr), 64'(2));
    reset = 1'b0;
    #1;
    check("arst_busy", 64'(g_i[0].busy), 64'(0));
    check("arst_reading_frame", 64'(g_i[0].reading_frame), 64'(1));
    check("arst_fm_addr", 64'(g_i[0].fm_addr), 64'(0));
    check("arst_wt_addr", 64'(g_i[0].wt_addr), 64'(0));
    check("arst_mac_en", 64'(g_i[0].mac_en), 64'(0));
    check("arst_out_data", 64'(g_i[0].out_data), 64'(0));
    check("arst_out_valid", 64'(g_i[0].out_valid), 64'(0));
    frame_rdy[0] = 2'b01;
    @(negedge clock);
    tick;
    reset = 1'b1;
    run_frame(0, 0, 1'b0);
    check("rerun_result_1", 64'(g_i[0].out_data), 64'(20));

    // RD_LAT=0 and RD_LAT=3 builds: same results, periods 6 and 9
    tick;
    check("lat0_count", 64'(g_i[1].m_n), 64'(2));
    check("lat0_r0", 64'(g_i[1].m_data[0]), 64'(15));
    check("lat0_r1", 64'(g_i[1].m_data[1]), 64'(20));
    check("lat0_idx1", 64'(g_i[1].m_idx[1]), 64'(1));
    check("lat0_period", 64'(g_i[1].m_cyc[1] - g_i[1].m_cyc[0]), 64'(6));
    check("lat0_frame_done", 64'(g_i[1].fd_n), 64'(1));
    check("lat0_idle", 64'(g_i[1].busy), 64'(0));
    check("lat3_count", 64'(g_i[2].m_n), 64'(2));
    check("lat3_r0", 64'(g_i[2].m_data[0]), 64'(15));
    check("lat3_r1", 64'(g_i[2].m_data[1]), 64'(20));
    check("lat3_idx1", 64'(g_i[2].m_idx[1]), 64'(1));
    check("lat3_period", 64'(g_i[2].m_cyc[1] - g_i[2].m_cyc[0]), 64'(9));
    check("lat3_frame_done", 64'(g_i[2].fd_n), 64'(1));
    check("lat3_idle", 64'(g_i[2].busy), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
